// File: rtl/ask_demod_if.sv
// ask_demod_if: sample stream in, recovered bit stream out.
// The master drives samples and observes decisions; the demodulator takes the slave modport.
interface ask_demod_if;
    logic       sample_en;
    logic [9:0] ask_code_sin_in;
    logic       m_ser_code_out;
    logic       bit_valid;
    logic       carrier_det;

    modport master (
        output sample_en,
        output ask_code_sin_in,
        input  m_ser_code_out,
        input  bit_valid,
        input  carrier_det
    );

    modport slave (
        input  sample_en,
        input  ask_code_sin_in,
        output m_ser_code_out,
        output bit_valid,
        output carrier_det
    );
endinterface

// File: rtl/ask_demod.sv
// ask_demod: non-coherent on/off-keyed demodulator.
// Integrates the sample stream over each bit window and slices against a threshold.
// Bit timing is taken from the first sample above DETECT_LEVEL; IDLE_BITS zeros in a row
// drop back to acquisition.
// Optional macro ASK_DEMOD_CNT_EN: count above-level samples instead of summing amplitude.
module ask_demod #(
    parameter int unsigned SPB          = 64,
    parameter int unsigned DETECT_LEVEL = 64,
    parameter int unsigned SUM_THRESH   = 8192,
    parameter int unsigned IDLE_BITS    = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    ask_demod_if.slave bus
);

`ifdef ASK_DEMOD_CNT_EN
    localparam int unsigned ACC_W = $clog2(SPB) + 1;
    localparam logic [ACC_W-1:0] THRESH = ACC_W'(SPB / 4);
`else
    localparam int unsigned ACC_W = 10 + $clog2(SPB);
    localparam logic [ACC_W-1:0] THRESH = ACC_W'(SUM_THRESH);
`endif
    localparam int unsigned CNT_W  = $clog2(SPB);
    localparam int unsigned ZRUN_W = $clog2(IDLE_BITS + 1);

    localparam logic [9:0]        DET_LVL  = 10'(DETECT_LEVEL);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SPB - 1);
    localparam logic [ZRUN_W-1:0] ZRUN_MAX = ZRUN_W'(IDLE_BITS);

    typedef enum logic {StIdle, StTrack} state_t;

    state_t              r_state, w_state_nxt;
    logic [ACC_W-1:0]    r_acc, w_acc_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [ZRUN_W-1:0]   r_zrun, w_zrun_nxt;
    logic                r_code, w_code_nxt;
    logic                r_valid, w_valid_nxt;

    logic                w_det;
    logic [ACC_W-1:0]    w_inc;
    logic [ACC_W-1:0]    w_sum;
    logic                w_bit;
    logic [ZRUN_W-1:0]   w_zrun_inc;

    assign w_det = bus.ask_code_sin_in > DET_LVL;

`ifdef ASK_DEMOD_CNT_EN
    assign w_inc = {{(ACC_W-1){1'b0}}, w_det};
`else
    assign w_inc = ACC_W'(bus.ask_code_sin_in);
`endif

    // Window total including the sample being consumed now; only meaningful at window end.
    assign w_sum      = r_acc + w_inc;
    assign w_bit      = w_sum > THRESH;
    assign w_zrun_inc = (r_zrun == ZRUN_MAX) ? r_zrun : r_zrun + ZRUN_W'(1);

    // Next-state logic: acquisition, window integration and bit decision.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_zrun_nxt  = r_zrun;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_acc_nxt  = '0;
                w_cnt_nxt  = '0;
                w_zrun_nxt = '0;
                if (bus.sample_en && w_det) begin
                    // Detecting sample is window sample 0.
                    w_state_nxt = StTrack;
                    w_acc_nxt   = w_inc;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            StTrack: begin
                if (bus.sample_en) begin
                    if (r_cnt != CNT_LAST) begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else begin
                        w_code_nxt  = w_bit;
                        w_valid_nxt = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        if (w_bit) begin
                            w_zrun_nxt = '0;
                        end else if (w_zrun_inc >= ZRUN_MAX) begin
                            w_state_nxt = StIdle;
                            w_zrun_nxt  = '0;
                        end else begin
                            w_zrun_nxt = w_zrun_inc;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_zrun  <= '0;
            r_code  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_zrun  <= w_zrun_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign bus.m_ser_code_out = r_code;
    assign bus.bit_valid      = r_valid;
    assign bus.carrier_det    = (r_state == StTrack);

endmodule

// File: tb/tb_ask_demod.sv
// tb_ask_demod: directed stimulus with a scoreboard of expected decisions and pulse cycles.
module tb_ask_demod;
    localparam int SPB = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;
    exp_t exp_q[$];

    ask_demod_if bus();

    ask_demod #(
        .SPB          (64),
        .DETECT_LEVEL (64),
        .SUM_THRESH   (8192),
        .IDLE_BITS    (8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Carrier: offset sine, 16 samples per period, spanning 0..1023.
    function automatic logic [9:0] samp(input logic b, input int i);
        real r;
        if (!b) return 10'd0;
        r = 511.5 + 511.5 * $sin(2.0 * 3.14159265358979 * real'(i) / 16.0);
        return 10'($rtoi(r));
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic [9:0] v);
        bus.sample_en       = en;
        bus.ask_code_sin_in = v;
        @(posedge clk);
        #1;
    endtask

    // Expect a pulse visible right after the next rising edge.
    task automatic push(input logic b);
        exp_t e;
        e.b   = b;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic send_win(input logic b, input int gap, input int first);
        for (int i = first; i < SPB; i++) begin
            for (int g = 1; g < gap; g++) step(1'b0, 10'd1000);
            if (i == SPB - 1) push(b);
            step(1'b1, samp(b, i));
        end
    endtask

    task automatic send_vals(input logic b, input logic [9:0] v, input int n,
                             input logic [9:0] rest, input logic [9:0] last);
        for (int i = 0; i < SPB; i++) begin
            if (i == SPB - 1) begin
                push(b);
                step(1'b1, last);
            end else begin
                step(1'b1, (i < n) ? v : rest);
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step(1'b0, 10'd0);
        rst_n = 1'b1;
        chk("reset_carrier", bus.carrier_det, 1'b0);
    endtask

    // Decision monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.bit_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errors++;
                $error("FAIL unexpected_pulse at cycle %0d observed bit %b expected none",
                       cyc, bus.m_ser_code_out);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                assert (bus.m_ser_code_out === e.b) else begin
                    n_errors++;
                    $error("FAIL bit_value observed %b expected %b", bus.m_ser_code_out, e.b);
                end
                n_checks++;
                assert (cyc === e.cyc) else begin
                    n_errors++;
                    $error("FAIL pulse_cycle observed %0d expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.sample_en       = 1'b0;
        bus.ask_code_sin_in = 10'd0;

        // Reset held with carrier present.
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, samp(1'b1, i));
            chk("rst_bit_valid", bus.bit_valid, 1'b0);
            chk("rst_code", bus.m_ser_code_out, 1'b0);
            chk("rst_carrier", bus.carrier_det, 1'b0);
        end
        rst_n = 1'b1;

        // Pattern 1,0,1,1,0 with continuous strobe.
        step(1'b1, samp(1'b1, 0));
        chk("acq_carrier_rise", bus.carrier_det, 1'b1);
        send_win(1'b1, 1, 1);
        for (int k = 1; k < 5; k++) send_win(pat[k], 1, 0);

        // Idle drop: one '1' then eight zeros, then re-acquire.
        send_win(1'b1, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            send_win(1'b0, 1, 0);
            chk("idle_carrier", bus.carrier_det, (k < 8));
        end
        chk("idle_code_held", bus.m_ser_code_out, 1'b0);
        step(1'b1, 10'd0);
        step(1'b1, 10'd0);
        chk("idle_discard", bus.carrier_det, 1'b0);
        step(1'b1, samp(1'b1, 0));
        chk("reacq_carrier", bus.carrier_det, 1'b1);
        send_win(1'b1, 1, 1);

        // Gapped strobe: every third cycle.
        pulse_reset();
        send_win(1'b1, 3, 0);
        send_win(1'b0, 3, 0);

        // Threshold boundary.
        pulse_reset();
`ifdef ASK_DEMOD_CNT_EN
        send_vals(1'b0, 10'd100, 16, 10'd0, 10'd0);
        send_vals(1'b1, 10'd100, 17, 10'd0, 10'd0);
`else
        send_vals(1'b0, 10'd128, 64, 10'd0, 10'd128);
        send_vals(1'b1, 10'd128, 64, 10'd0, 10'd129);
`endif

        // Mid-window reset at sample 30.
        pulse_reset();
        for (int i = 0; i < 30; i++) step(1'b1, samp(1'b1, i));
        chk("mid_carrier_before", bus.carrier_det, 1'b1);
        rst_n = 1'b0;
        step(1'b1, samp(1'b1, 30));
        rst_n = 1'b1;
        chk("mid_bit_valid", bus.bit_valid, 1'b0);
        chk("mid_carrier", bus.carrier_det, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 10'd0);
        chk("mid_stay_idle", bus.carrier_det, 1'b0);
        send_win(1'b1, 1, 0);

        for (int i = 0; i < 4; i++) step(1'b0, 10'd0);
        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_errors++;
            $error("FAIL missing_pulses observed %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ask_demod.md
# ask_demod

Non-coherent ASK demodulator: recovers the serial code from the 10-bit on/off-keyed sine stream produced by the ASK modulator, where the carrier is passed for a '1' and forced to 10'd0 for a '0'. The demodulator integrates the unsigned sample amplitude over each bit window and makes a threshold decision. It acquires bit timing from the first carrier burst and returns to idle after a run of zero bits. It sits in the receive path, directly fed by the modulator output (loopback) or by an ADC delivering the same format.

## Interface
- SPB, 64: samples per bit, must be at least 4. The accumulator width is ACC_W = 10 + $clog2(SPB).
- DETECT_LEVEL, 64: a sample strictly greater than this counts as carrier present (start detect, and count mode).
- SUM_THRESH, 8192: a bit-window sum strictly greater than this decides '1'. This is about one quarter of the mean-carrier sum at the default SPB.
- IDLE_BITS, 8: the number of consecutive '0' decisions that drop the block back to IDLE.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- sample_en, input, 1: sample strobe; one 10-bit sample is consumed per asserted cycle.
- ask_code_sin_in, input, 10: unsigned ASK sample in the range 0..1023.
- m_ser_code_out, output, 1: recovered bit; registered and held until the next decision.
- bit_valid, output, 1: single-cycle pulse when m_ser_code_out updates.
- carrier_det, output, 1: high while in TRACK.

## Operation
States: IDLE, TRACK.

In IDLE:
- acc = 0, cnt = 0, zrun = 0, carrier_det = 0.
- A sample_en cycle with ask_code_sin_in > DETECT_LEVEL moves the block to TRACK.
- That sample becomes window sample 0: acc = sample, cnt = 1.
- Samples at or below DETECT_LEVEL are discarded.

In TRACK (carrier_det = 1), on each sample_en cycle:
- If cnt < SPB-1: acc += sample, cnt++.
- If cnt == SPB-1 (window end), compute sum = acc + sample in ACC_W bits.
  - Decision: bit = (sum > SUM_THRESH).
  - m_ser_code_out ← bit, bit_valid ← 1.
  - acc ← 0, cnt ← 0.
- On bit = 1: zrun ← 0.
- On bit = 0: zrun++. If zrun reaches IDLE_BITS, the block goes to IDLE after emitting this bit. m_ser_code_out holds the last value (0).

Other rules:
- sample_en low means every register holds (no timeout).
- Arithmetic: ACC_W covers SPB × 1023 with no overflow; saturation is not needed.
- zrun saturates at IDLE_BITS.

## Timing
- Reset values: m_ser_code_out = 0, bit_valid = 0, carrier_det = 0, state = IDLE, acc = cnt = zrun = 0.
- Reset takes effect at the first rising edge with rst_n low. Reset mid-window discards the partial window and emits no pulse.
- Decision latency: bit_valid and m_ser_code_out update on the edge that samples the window-end sample_en cycle. bit_valid is high the following cycle only.
- carrier_det rises on the edge that captures the detecting sample.
- carrier_det falls on the same edge that issues the IDLE_BITS-th zero decision. That decision's bit_valid pulse is still emitted.
- Back-to-back windows: window sample 0 of the next bit is accepted on the cycle right after the window end. No dead cycle.
- Re-acquisition from IDLE may occur on the cycle right after carrier_det falls.
- Decisions are spaced at least SPB cycles apart; there is no back-pressure.

## Configuration
ASK_DEMOD_CNT_EN selects the decision metric.

With the macro defined:
- acc counts samples with ask_code_sin_in > DETECT_LEVEL, incrementing by 1 per such sample.
- The window count includes window sample 0.
- bit = (count > SPB/4).
- SUM_THRESH is unused.
- The accumulator is $clog2(SPB)+1 bits.

Without the macro: amplitude-sum decision as described above.

All other behaviour is identical in both modes.

## Test plan
- Reset: hold rst_n = 0 for 5 cycles with sample_en = 1 and carrier input present. Required: all outputs 0 and carrier_det = 0. After release, the first bit_valid comes 64 samples after the first sample > 64.
- Pattern 1,0,1,1,0 with SPB = 64 (full-scale 10k sine for '1', 10'd0 for '0', sample_en every cycle). Required: 5 bit_valid pulses, 64 cycles apart, with m_ser_code_out = 1,0,1,1,0.
- Idle drop: the single bit '1' followed by 8 zero bits. Required: 9 decisions (1 then eight 0s). carrier_det falls with the 9th pulse. A carrier burst 3 cycles later re-acquires.
- Gapped strobe: sample_en asserted every 3rd cycle, pattern 1,0. Required: identical bit values, with pulses 192 cycles apart.
- Threshold boundary: force a window sum of exactly 8192, then 8193. Required: decisions 0, then 1. Under ASK_DEMOD_CNT_EN, 16 vs 17 detected samples give 0 vs 1.
- Mid-window reset: assert rst_n = 0 for 1 cycle at sample 30 of a window. Required: no bit_valid, state returns to IDLE, and re-acquisition occurs on the next sample > 64.
